// File: rtl/bf_core.sv
// Brainfuck execution core with width-generic cells and pointers.
// Program and data memories are external and have a 1-cycle synchronous read.
// Byte I/O uses valid/ready handshakes. A nonzero status code stops execution.
module bf_core #(
  parameter int PROG_ADDR_W = 8,
  parameter int DATA_ADDR_W = 8,
  parameter int CELL_W      = 8,
  parameter int STACK_DEPTH = 8,
  parameter bit PTR_WRAP    = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  output logic [PROG_ADDR_W-1:0] prog_addr,
  output logic                   prog_ren,
  input  logic [7:0]             prog_rdata,
  output logic [DATA_ADDR_W-1:0] data_addr,
  output logic                   data_ren,
  input  logic [CELL_W-1:0]      data_rdata,
  output logic                   data_wen,
  output logic [CELL_W-1:0]      data_wdata,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   halted,
  output logic [2:0]             status
);

  localparam int SP_W    = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = PROG_ADDR_W + 1;

  localparam logic [2:0] ST_RUN             = 3'd0;
  localparam logic [2:0] ST_DONE            = 3'd1;
  localparam logic [2:0] ST_DP_RANGE        = 3'd2;
  localparam logic [2:0] ST_STACK_OVF       = 3'd3;
  localparam logic [2:0] ST_UNMATCHED_CLOSE = 3'd4;
  localparam logic [2:0] ST_UNMATCHED_OPEN  = 3'd5;

  localparam logic [7:0] CH_RIGHT = 8'h3E;  // '>'
  localparam logic [7:0] CH_LEFT  = 8'h3C;  // '<'
  localparam logic [7:0] CH_INC   = 8'h2B;  // '+'
  localparam logic [7:0] CH_DEC   = 8'h2D;  // '-'
  localparam logic [7:0] CH_OUT   = 8'h2E;  // '.'
  localparam logic [7:0] CH_IN    = 8'h2C;  // ','
  localparam logic [7:0] CH_OPEN  = 8'h5B;  // '['
  localparam logic [7:0] CH_CLOSE = 8'h5D;  // ']'
  localparam logic [7:0] CH_END   = 8'h00;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_SCAN_F, S_SCAN_D, S_OUT_WAIT, S_IN_WAIT, S_HALT
  } state_t;

  state_t                 state, state_n;
  logic [PROG_ADDR_W-1:0] pc, pc_n, pc_inc, stack_top;
  logic [DATA_ADDR_W-1:0] dp, dp_n;
  logic [SP_W-1:0]        sp;
  logic [IDX_W-1:0]       top_idx;
  logic [DEPTH_W-1:0]     depth, depth_n;
  logic [7:0]             instr;
  logic [2:0]             status_n;
  logic                   out_valid_n;
  logic [7:0]             out_data_n;
  logic                   push, pop, go;
  logic                   data_ren_c, data_wen_c;
  logic [CELL_W-1:0]      data_wdata_c;
  logic                   cell_zero, stack_full, stack_empty;
  logic [PROG_ADDR_W-1:0] stack_mem [STACK_DEPTH];

  // Memory strobes are Mealy outputs: they must never fire while frozen or in reset.
  assign go          = en & ~reset;
  assign pc_inc      = pc + PROG_ADDR_W'(1);
  assign top_idx     = IDX_W'(sp - SP_W'(1));
  assign stack_top   = stack_mem[top_idx];
  assign cell_zero   = (data_rdata == '0);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);

  assign prog_addr  = pc;
  assign prog_ren   = ((state == S_FETCH) || (state == S_SCAN_F)) && !reset;
  assign data_addr  = dp;
  assign data_ren   = data_ren_c & go;
  assign data_wen   = data_wen_c & go;
  assign data_wdata = go ? data_wdata_c : '0;
  assign in_ready   = (state == S_IN_WAIT);
  assign halted     = (status != ST_RUN);

  // Next-state, register updates and memory strobes for the current state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n      = state;
    pc_n         = pc;
    dp_n         = dp;
    depth_n      = depth;
    status_n     = status;
    out_valid_n  = out_valid;
    out_data_n   = out_data;
    push         = 1'b0;
    pop          = 1'b0;
    data_ren_c   = 1'b0;
    data_wen_c   = 1'b0;
    data_wdata_c = '0;
    unique case (state)
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        unique case (prog_rdata)
          CH_RIGHT: begin
            if (!PTR_WRAP && dp == {DATA_ADDR_W{1'b1}}) begin
              status_n = ST_DP_RANGE;
              state_n  = S_HALT;
            end else begin
              dp_n    = dp + DATA_ADDR_W'(1);
              pc_n    = pc_inc;
              state_n = S_FETCH;
            end
          end
          CH_LEFT: begin
            if (!PTR_WRAP && dp == '0) begin
              status_n = ST_DP_RANGE;
              state_n  = S_HALT;
            end else begin
              dp_n    = dp - DATA_ADDR_W'(1);
              pc_n    = pc_inc;
              state_n = S_FETCH;
            end
          end
          CH_INC, CH_DEC, CH_OUT, CH_OPEN, CH_CLOSE: begin
            data_ren_c = 1'b1;
            state_n    = S_EXEC;
          end
          CH_IN: state_n = S_IN_WAIT;
          CH_END: begin
            status_n = ST_DONE;
            state_n  = S_HALT;
          end
          default: begin
            pc_n    = pc_inc;
            state_n = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        state_n = S_FETCH;
        pc_n    = pc_inc;
        unique case (instr)
          CH_INC: begin
            data_wen_c   = 1'b1;
            data_wdata_c = data_rdata + CELL_W'(1);
          end
          CH_DEC: begin
            data_wen_c   = 1'b1;
            data_wdata_c = data_rdata - CELL_W'(1);
          end
          CH_OUT: begin
            pc_n        = pc;
            out_data_n  = data_rdata[7:0];
            out_valid_n = 1'b1;
            state_n     = S_OUT_WAIT;
          end
          CH_OPEN: begin
            if (cell_zero) begin
              depth_n = DEPTH_W'(1);
              state_n = S_SCAN_F;
            end else if (stack_full) begin
              // A full stack wins over the push: nothing is written.
              pc_n     = pc;
              status_n = ST_STACK_OVF;
              state_n  = S_HALT;
            end else begin
              push = 1'b1;
            end
          end
          CH_CLOSE: begin
            if (stack_empty) begin
              pc_n     = pc;
              status_n = ST_UNMATCHED_CLOSE;
              state_n  = S_HALT;
            end else if (!cell_zero) begin
              pc_n = stack_top;
            end else begin
              pop = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_SCAN_F: state_n = S_SCAN_D;
      S_SCAN_D: begin
        pc_n    = pc_inc;
        state_n = S_SCAN_F;
        unique case (prog_rdata)
          CH_OPEN: depth_n = depth + DEPTH_W'(1);
          CH_CLOSE: begin
            depth_n = depth - DEPTH_W'(1);
            if (depth == DEPTH_W'(1)) state_n = S_FETCH;
          end
          CH_END: begin
            pc_n     = pc;
            status_n = ST_UNMATCHED_OPEN;
            state_n  = S_HALT;
          end
          default: ;
        endcase
      end
      S_OUT_WAIT: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          pc_n        = pc_inc;
          state_n     = S_FETCH;
        end
      end
      S_IN_WAIT: begin
        if (in_valid) begin
          data_wen_c   = 1'b1;
          data_wdata_c = CELL_W'(in_data);
          pc_n         = pc_inc;
          state_n      = S_FETCH;
        end
      end
      S_HALT: ;
      default: state_n = S_HALT;
    endcase
  end

  // Architectural state; en=0 freezes everything, including reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (en) begin
      if (reset) begin
        state     <= S_FETCH;
        pc        <= '0;
        dp        <= '0;
        sp        <= '0;
        depth     <= '0;
        instr     <= '0;
        status    <= ST_RUN;
        out_valid <= 1'b0;
        out_data  <= '0;
      end else begin
        state     <= state_n;
        pc        <= pc_n;
        dp        <= dp_n;
        depth     <= depth_n;
        status    <= status_n;
        out_valid <= out_valid_n;
        out_data  <= out_data_n;
        if (state == S_DECODE) instr <= prog_rdata;
        if (push)     sp <= sp + SP_W'(1);
        else if (pop) sp <= sp - SP_W'(1);
      end
    end
  end

  // Loop-return stack storage.
  always_ff @(posedge clk) begin
    // NOTE: the stack array has no reset; sp alone defines which entries are valid.
    if (go && push) stack_mem[sp[IDX_W-1:0]] <= pc_inc;
  end

endmodule

// File: tb/tb_bf_core.sv
// Testbench for bf_core: directed programs checked against a Brainfuck interpreter model.
// Instance a uses default parameters; instance b uses CELL_W=12 and PTR_WRAP=1.
module tb_bf_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, out_ready, in_valid, mem_clear;
  logic [7:0] in_data;

  logic [7:0]  a_prog_addr, a_prog_rdata, a_data_addr, a_data_rdata, a_data_wdata, a_out_data;
  logic        a_prog_ren, a_data_ren, a_data_wen, a_out_valid, a_in_ready, a_halted;
  logic [2:0]  a_status;
  logic [7:0]  b_prog_addr, b_prog_rdata, b_data_addr, b_out_data;
  logic [11:0] b_data_rdata, b_data_wdata;
  logic        b_prog_ren, b_data_ren, b_data_wen, b_out_valid, b_in_ready, b_halted;
  logic [2:0]  b_status;

  logic [7:0]  prog_mem [256];
  logic [7:0]  dmem_a   [256];
  logic [11:0] dmem_b   [256];

  int checks = 0;
  int errors = 0;
  byte unsigned exp_q[$];
  bit   cmp_on = 1'b0;
  int   a_xfers, b_xfers;
  logic [7:0] b_last_out;

  byte unsigned mq[$];
  byte unsigned none[$];
  byte unsigned ins[$];
  int mst, mdp, cyc, guard;

  bf_core u_a (
    .clk(clk), .reset(reset), .en(en),
    .prog_addr(a_prog_addr), .prog_ren(a_prog_ren), .prog_rdata(a_prog_rdata),
    .data_addr(a_data_addr), .data_ren(a_data_ren), .data_rdata(a_data_rdata),
    .data_wen(a_data_wen), .data_wdata(a_data_wdata),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
    .halted(a_halted), .status(a_status)
  );

  bf_core #(.CELL_W(12), .PTR_WRAP(1'b1)) u_b (
    .clk(clk), .reset(reset), .en(en),
    .prog_addr(b_prog_addr), .prog_ren(b_prog_ren), .prog_rdata(b_prog_rdata),
    .data_addr(b_data_addr), .data_ren(b_data_ren), .data_rdata(b_data_rdata),
    .data_wen(b_data_wen), .data_wdata(b_data_wdata),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
    .halted(b_halted), .status(b_status)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Synchronous-read program and data memories for both instances.
  initial begin
    forever begin
      @(posedge clk);
      if (a_prog_ren) a_prog_rdata <= prog_mem[a_prog_addr];
      if (b_prog_ren) b_prog_rdata <= prog_mem[b_prog_addr];
      if (mem_clear) begin
        for (int i = 0; i < 256; i++) begin
          dmem_a[i] <= '0;
          dmem_b[i] <= '0;
        end
      end else begin
        if (a_data_wen) dmem_a[a_data_addr] <= a_data_wdata;
        if (a_data_ren) a_data_rdata <= dmem_a[a_data_addr];
        if (b_data_wen) dmem_b[b_data_addr] <= b_data_wdata;
        if (b_data_ren) b_data_rdata <= dmem_b[b_data_addr];
      end
    end
  end

  // Output compare: every cycle a byte is offered it must equal the model's next byte.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on && en && !reset && a_out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_extra", 32'(a_out_valid), 32'd0);
        end else begin
          check("out_data", 32'(a_out_data), 32'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            a_xfers++;
          end
        end
      end
      if (en && !reset && b_out_valid && out_ready) begin
        b_last_out = b_out_data;
        b_xfers++;
      end
    end
  end

  // Interpreter model: runs the program by the language rules, not by cycles.
  task automatic model_run(input string prog, input byte unsigned inq[$], input int cell_w,
                           input bit wrap, output byte unsigned outs[$], output int st,
                           output int fdp);
    int cells[256];
    int stk[$];
    int pc, dp, depth, steps, mask;
    byte unsigned c;
    foreach (cells[i]) cells[i] = 0;
    outs = {};
    st = 0; pc = 0; dp = 0; steps = 0;
    mask = (1 << cell_w) - 1;
    while (st == 0 && steps < 20000) begin
      steps++;
      c = (pc < prog.len()) ? prog[pc] : 8'h00;
      case (c)
        8'h3E: if (dp == 255 && !wrap) st = 2; else begin dp = (dp + 1) % 256; pc++; end
        8'h3C: if (dp == 0 && !wrap) st = 2; else begin dp = (dp + 255) % 256; pc++; end
        8'h2B: begin cells[dp] = (cells[dp] + 1) & mask; pc++; end
        8'h2D: begin cells[dp] = (cells[dp] + mask) & mask; pc++; end
        8'h2E: begin outs.push_back(8'(cells[dp])); pc++; end
        8'h2C: begin cells[dp] = (inq.size() > 0) ? int'(inq.pop_front()) : 0; pc++; end
        8'h5B: begin
          if (cells[dp] == 0) begin
            depth = 1;
            pc++;
            while (depth > 0 && st == 0) begin
              c = (pc < prog.len()) ? prog[pc] : 8'h00;
              if (c == 8'h5B) depth++;
              else if (c == 8'h5D) depth--;
              else if (c == 8'h00) st = 5;
              if (st == 0) pc++;
            end
          end else if (stk.size() == 8) st = 3;
          else begin stk.push_back(pc + 1); pc++; end
        end
        8'h5D: begin
          if (stk.size() == 0) st = 4;
          else if (cells[dp] != 0) pc = stk[$];
          else begin void'(stk.pop_back()); pc++; end
        end
        8'h00: st = 1;
        default: pc++;
      endcase
    end
    fdp = dp;
  endtask

  task automatic start(input string prog);
    en = 1'b1; reset = 1'b1; out_ready = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    for (int i = 0; i < 256; i++) prog_mem[i] = (i < prog.len()) ? prog[i] : 8'h00;
    mem_clear = 1'b1;
    a_xfers = 0; b_xfers = 0; b_last_out = 8'h00;
    repeat (2) begin @(posedge clk); #1; end
    mem_clear = 1'b0; reset = 1'b0;
  endtask

  // Returns the number of cycles until instance a halts, then waits for b as well.
  task automatic wait_halt(input string name, output int c);
    int g;
    c = 0;
    while (!a_halted && c < 3000) begin @(posedge clk); #1; c++; end
    if (!a_halted) check({name, "_a_timeout"}, 32'(a_halted), 32'd1);
    g = 0;
    while (!b_halted && g < 3000) begin @(posedge clk); #1; g++; end
    if (!b_halted) check({name, "_b_timeout"}, 32'(b_halted), 32'd1);
  endtask

  task automatic finish_checks(input string name);
    check({name, "_status"}, 32'(a_status), 32'(mst));
    check({name, "_halted"}, 32'(a_halted), 32'(mst != 0));
    check({name, "_dp"}, 32'(a_data_addr), 32'(mdp));
    check({name, "_missing_out"}, 32'(exp_q.size()), 32'd0);
    cmp_on = 1'b0;
  endtask

  task automatic run_prog(input string name, input string prog, output int c);
    model_run(prog, none, 8, 1'b0, mq, mst, mdp);
    exp_q = mq;
    start(prog);
    cmp_on = 1'b1;
    wait_halt(name, c);
    finish_checks(name);
  endtask

  task automatic wait_out_valid(input string name);
    int g = 0;
    while (!a_out_valid && g < 200) begin @(posedge clk); #1; g++; end
    if (!a_out_valid) check({name, "_ov_timeout"}, 32'(a_out_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    en = 1'b1; reset = 1'b1; out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    mem_clear = 1'b1;
    for (int i = 0; i < 256; i++) prog_mem[i] = 8'h00;
    repeat (3) begin @(posedge clk); #1; end

    // Reset state
    check("rst_prog_ren", 32'(a_prog_ren), 32'd0);
    check("rst_data_ren", 32'(a_data_ren), 32'd0);
    check("rst_data_wen", 32'(a_data_wen), 32'd0);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd0);
    check("rst_status", 32'(a_status), 32'd0);
    check("rst_pc", 32'(a_prog_addr), 32'd0);
    check("rst_dp", 32'(a_data_addr), 32'd0);
    check("rst_out_data", 32'(a_out_data), 32'd0);
    check("rst_wdata", 32'(a_data_wdata), 32'd0);

    // Hand-computed pins on the model itself
    model_run("+++.", none, 8, 1'b0, mq, mst, mdp);
    check("pin_len", 32'(mq.size()), 32'd1);
    check("pin_val", 32'(mq[0]), 32'd3);
    check("pin_st", 32'(mst), 32'd1);
    model_run("-.", none, 12, 1'b1, mq, mst, mdp);
    check("pin_neg12", 32'(mq[0]), 32'hFF);
    model_run("<", none, 8, 1'b1, mq, mst, mdp);
    check("pin_wrap_st", 32'(mst), 32'd1);
    check("pin_wrap_dp", 32'(mdp), 32'd255);
    model_run("[+.].", none, 8, 1'b0, mq, mst, mdp);
    check("pin_skip", 32'(mq.size()), 32'd1);

    // Main function
    run_prog("inc3", "+++.", cyc);
    check("inc3_cycles", 32'(cyc), 32'd15);
    check("inc3_xfers", 32'(a_xfers), 32'd1);

    run_prog("neg", "-.", cyc);
    check("neg_b_wdata", 32'(dmem_b[0]), 32'hFFF);
    check("neg_b_out", 32'(b_last_out), 32'hFF);
    check("neg_b_xfers", 32'(b_xfers), 32'd1);

    run_prog("skip", "[+.].", cyc);
    check("skip_xfers", 32'(a_xfers), 32'd1);
    run_prog("nest_skip", "[[-]+.]+.", cyc);
    run_prog("mul", "++[>+++<-]>.", cyc);
    run_prog("mul25", ">+++++[<+++++>-]<.>.", cyc);
    run_prog("noop", "a+b.", cyc);

    // Boundaries and errors
    run_prog("dp_under", "<", cyc);
    check("dp_under_pc", 32'(a_prog_addr), 32'd0);
    check("dp_under_b_status", 32'(b_status), 32'd1);
    check("dp_under_b_dp", 32'(b_data_addr), 32'd255);
    run_prog("stack_ovf", "+[[[[[[[[[", cyc);
    check("stack_ovf_pc", 32'(a_prog_addr), 32'd9);
    check("stack_ovf_b", 32'(b_status), 32'd3);
    run_prog("close", "]", cyc);
    run_prog("open", "[", cyc);

    // Input with in_valid delayed five cycles
    ins = {8'h41};
    model_run(",+.", ins, 8, 1'b0, mq, mst, mdp);
    exp_q = mq;
    start(",+.");
    cmp_on = 1'b1;
    guard = 0;
    while (!a_in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    repeat (5) begin
      check("in_hold", 32'(a_in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = 8'h41;
    check("in_ready_at_xfer", 32'(a_in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in_drop", 32'(a_in_ready), 32'd0);
    wait_halt("input", cyc);
    finish_checks("input");

    // out_ready low for 10 cycles
    model_run("+++.", none, 8, 1'b0, mq, mst, mdp);
    exp_q = mq;
    start("+++.");
    out_ready = 1'b0;
    cmp_on = 1'b1;
    wait_out_valid("stall");
    repeat (10) begin
      check("stall_valid", 32'(a_out_valid), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_halt("stall", cyc);
    finish_checks("stall");
    check("stall_xfers", 32'(a_xfers), 32'd1);

    // en=0 in the middle of an output handshake
    model_run("+.", none, 8, 1'b0, mq, mst, mdp);
    exp_q = mq;
    start("+.");
    out_ready = 1'b0;
    cmp_on = 1'b1;
    wait_out_valid("freeze");
    en = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("freeze_valid", 32'(a_out_valid), 32'd1);
      check("freeze_data", 32'(a_out_data), 32'd1);
    end
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("freeze_ready_valid", 32'(a_out_valid), 32'd1);
    end
    check("freeze_no_xfer", 32'(a_xfers), 32'd0);
    en = 1'b1;
    wait_halt("freeze", cyc);
    finish_checks("freeze");
    check("freeze_xfers", 32'(a_xfers), 32'd1);

    // Reset during an output handshake
    start("+.");
    out_ready = 1'b0;
    wait_out_valid("rst_out");
    reset = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid_drop", 32'(a_out_valid), 32'd0);
    check("rst_out_pc", 32'(a_prog_addr), 32'd0);
    check("rst_out_status", 32'(a_status), 32'd0);
    reset = 1'b0;

    // Reset during an input handshake
    start(",");
    guard = 0;
    while (!a_in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    @(posedge clk); #1;
    check("rst_in_ready_drop", 32'(a_in_ready), 32'd0);
    @(posedge clk); #1;
    check("rst_in_no_write", 32'(dmem_a[0]), 32'd0);
    reset = 1'b0; in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
